curve25519_arbiter: RTL and testbench

- Shares one curve25519 scalar-multiplication core between NREQ requesters.
- Round-robin arbitration over valid/ready request ports; latches scalar and point; pulses core `start`; waits for `done`.
- Returns the result on a single valid/ready response port, tagged with the requester id.
- A watchdog aborts jobs whose core never signals `done`.

---
 rtl/curve25519_arbiter.sv | 140 ++++++++++++++
 tb/tb_curve25519_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/curve25519_arbiter.sv
// Round-robin front end sharing one curve25519 scalar-multiplication core between NREQ requesters.
// Accept to core_start is 1 cycle; core_done to resp_valid is 1 cycle; resp_ready low holds RESP and blocks new grants.
module curve25519_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 1048576
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*255-1:0]   req_n,
  input  logic [NREQ*255-1:0]   req_q,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [254:0]          resp_out,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  core_start,
  output logic [254:0]          core_n,
  output logic [254:0]          core_q,
  input  logic                  core_done,
  input  logic [254:0]          core_out
);

  localparam int NPAD = 1 << IDW;
  localparam int WDW  = $clog2(TIMEOUT) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_RESP} state_t;

  state_t          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  resp_id_q;
  logic [254:0]    resp_out_q;
  logic            resp_err_q;
  logic [254:0]    core_n_q;
  logic [254:0]    core_q_q;
  logic [WDW-1:0]  wd_q;

  // Pad the request vectors to 2**IDW entries so an IDW-bit id indexes them exactly.
  logic [NPAD-1:0] vld_ext;
  logic [254:0]    n_arr [NPAD];
  logic [254:0]    q_arr [NPAD];

  assign vld_ext = NPAD'(req_valid);

  for (genvar g = 0; g < NPAD; g++) begin : g_pad
    if (g < NREQ) begin : g_real
      assign n_arr[g] = req_n[255*g +: 255];
      assign q_arr[g] = req_q[255*g +: 255];
    end else begin : g_zero
      assign n_arr[g] = '0;
      assign q_arr[g] = '0;
    end
  end

  logic           gnt_vld;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand;
  int             scan_idx;

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    scan_idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % NREQ;
      cand     = IDW'(scan_idx);
      if (!gnt_vld && vld_ext[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && gnt_vld) req_ready = NREQ'(1) << gnt_idx;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= IDW'(NREQ - 1);
      resp_id_q  <= '0;
      resp_out_q <= '0;
      resp_err_q <= 1'b0;
      core_n_q   <= '0;
      core_q_q   <= '0;
      wd_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            core_n_q  <= n_arr[gnt_idx];
            core_q_q  <= q_arr[gnt_idx];
            resp_id_q <= gnt_idx;
            rr_ptr_q  <= gnt_idx;
            state_q   <= S_START;
          end
        end
        S_START: begin
          wd_q    <= '0;
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          // A done arriving on the expiry cycle still counts as a good result.
          if (core_done) begin
            resp_out_q <= core_out;
            resp_err_q <= 1'b0;
            state_q    <= S_RESP;
          end else if (wd_q == WD_LAST) begin
            resp_out_q <= '0;
            resp_err_q <= 1'b1;
            state_q    <= S_RESP;
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign resp_valid = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign core_start = (state_q == S_START);
  assign resp_id    = resp_id_q;
  assign resp_out   = resp_out_q;
  assign resp_err   = resp_err_q;
  assign core_n     = core_n_q;
  assign core_q     = core_q_q;

endmodule

// File: tb/tb_curve25519_arbiter.sv
// Directed bench for curve25519_arbiter: stub core (done 20 cycles after start, out = n^q, one golden X25519 vector).
module tb_curve25519_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TOUT = 64;

  localparam logic [255:0] GOLD256 =
    256'h743bcb585f9990edc2cfc4af84f6ff300729bb5facda28154362cd47a37de52f;
  localparam logic [254:0] GOLD = GOLD256[254:0];
  localparam logic [254:0] N1   = {1'b1, 254'b0};

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*255-1:0]  req_n;
  logic [NREQ*255-1:0]  req_q;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [IDW-1:0]       resp_id;
  logic [254:0]         resp_out;
  logic                 resp_err;
  logic                 busy;
  logic                 core_start;
  logic [254:0]         core_n;
  logic [254:0]         core_q;
  logic                 core_done;
  logic [254:0]         core_out;

  curve25519_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n), .req_q(req_q),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_out(resp_out), .resp_err(resp_err), .busy(busy),
    .core_start(core_start), .core_n(core_n), .core_q(core_q),
    .core_done(core_done), .core_out(core_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Stub core: no reset, restarts on every start pulse.
  logic [254:0] st_n = '0;
  logic [254:0] st_q = '0;
  int  cdown = 0;
  bit  stub_en = 1'b1;
  bit  late_done = 1'b0;

  always @(posedge clock) begin
    if (core_start) begin
      cdown <= 20;
      st_n  <= core_n;
      st_q  <= core_q;
    end else if (cdown > 0) begin
      cdown <= cdown - 1;
    end
  end
  assign core_done = (stub_en && cdown == 1) || late_done;
  assign core_out  = (st_n == N1 && st_q == 255'd9) ? GOLD : (st_n ^ st_q);

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [254:0] act, input logic [254:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  function automatic logic [254:0] dn(input int i);
    logic [254:0] r;
    r = '0;
    r[250 - i] = 1'b1;
    r[31:0] = 32'hCAFE_0000 | 32'(i);
    return r;
  endfunction

  function automatic logic [254:0] dq(input int i);
    logic [254:0] r;
    r = '0;
    r[100 + 8*i] = 1'b1;
    r[7:0] = 8'(i + 3);
    return r;
  endfunction

  task automatic wait_grant(output int g);
    g = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      for (int k = 0; k < NREQ; k++) if (req_ready[k]) g = k;
      if (g >= 0) break;
      step();
    end
    if (g < 0) timeout_fail("grant");
    else check("ready_onehot", 255'($onehot(req_ready)), 255'd1);
  endtask

  // One job from grant through response handshake; ends sampling the following IDLE cycle.
  task automatic run_job(input int hold, input bit tout, output int g, output int s,
                         output logic [254:0] o, output logic e, output int lat);
    int w;
    int extra;
    logic [IDW-1:0] id0;
    logic [254:0]   out0;
    stub_en = !tout;
    o = '0; e = 1'b0; lat = -1; s = cyc;
    wait_grant(g);
    if (g < 0) return;
    step();
    s = cyc;
    check("core_start", 255'(core_start), 255'd1);
    extra = 0;
    w = 0;
    step();
    while (!resp_valid && w < 200) begin
      if (core_start) extra++;
      step();
      w++;
    end
    if (!resp_valid) begin
      timeout_fail("resp_valid");
      return;
    end
    lat = cyc - s;
    check("no_restart", 255'(extra), 255'd0);
    o = resp_out;
    e = resp_err;
    id0 = resp_id;
    out0 = resp_out;
    if (hold > 0) begin
      resp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        step();
        check("hold_valid", 255'(resp_valid), 255'd1);
        check("hold_id", 255'(resp_id), 255'(id0));
        check("hold_out", resp_out, out0);
        check("hold_ready", 255'(req_ready), 255'd0);
        check("hold_start", 255'(core_start), 255'd0);
      end
      resp_ready = 1'b1;
    end
    step();
    check("idle_valid", 255'(resp_valid), 255'd0);
    check("idle_busy", 255'(busy), 255'd0);
    if (hold > 0) begin
      #1;
      check("regrant", 255'(|req_ready), 255'(|req_valid));
    end
  endtask

  typedef struct {
    logic [NREQ-1:0] mask;
    int              hold;
    bit              tout;
    int              exp_id;
    bit              chk_period;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int g, s, lat, prev_s, bad;
    logic [254:0] o;
    logic e;

    vecs[0]  = '{4'b1111, 0,  1'b0, 0, 1'b0};
    vecs[1]  = '{4'b1111, 0,  1'b0, 1, 1'b1};
    vecs[2]  = '{4'b1111, 0,  1'b0, 2, 1'b1};
    vecs[3]  = '{4'b1111, 0,  1'b0, 3, 1'b1};
    vecs[4]  = '{4'b1111, 0,  1'b0, 0, 1'b1};
    vecs[5]  = '{4'b1010, 0,  1'b0, 1, 1'b0};
    vecs[6]  = '{4'b1010, 50, 1'b0, 3, 1'b0};
    vecs[7]  = '{4'b0100, 0,  1'b0, 2, 1'b0};
    vecs[8]  = '{4'b0100, 0,  1'b0, 2, 1'b0};
    vecs[9]  = '{4'b0001, 0,  1'b1, 0, 1'b0};
    vecs[10] = '{4'b0110, 0,  1'b0, 1, 1'b0};

    reset = 1'b1;
    req_valid = '0;
    resp_ready = 1'b1;
    req_n = '0;
    req_q = '0;
    repeat (3) step();
    check("rst_ready", 255'(req_ready), 255'd0);
    check("rst_valid", 255'(resp_valid), 255'd0);
    check("rst_err", 255'(resp_err), 255'd0);
    check("rst_busy", 255'(busy), 255'd0);
    check("rst_start", 255'(core_start), 255'd0);
    check("rst_id", 255'(resp_id), 255'd0);
    check("rst_out", resp_out, '0);
    check("rst_core_n", core_n, '0);
    check("rst_core_q", core_q, '0);
    reset = 1'b0;

    // Golden X25519 vector on requester 0.
    req_n[0 +: 255] = N1;
    req_q[0 +: 255] = 255'd9;
    req_valid = 4'b0001;
    run_job(0, 1'b0, g, s, o, e, lat);
    req_valid = '0;
    check("gold_id", 255'(g), 255'd0);
    check("gold_out", o, GOLD);
    check("gold_err", 255'(e), 255'd0);
    check("gold_lat", 255'(lat), 255'd21);

    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_n[255*i +: 255] = dn(i);
      req_q[255*i +: 255] = dq(i);
    end

    prev_s = 0;
    for (int v = 0; v < 11; v++) begin
      req_valid = vecs[v].mask;
      run_job(vecs[v].hold, vecs[v].tout, g, s, o, e, lat);
      check($sformatf("v%0d_id", v), 255'(g), 255'(vecs[v].exp_id));
      check($sformatf("v%0d_out", v), o,
            vecs[v].tout ? 255'd0 : (dn(vecs[v].exp_id) ^ dq(vecs[v].exp_id)));
      check($sformatf("v%0d_err", v), 255'(e), 255'(vecs[v].tout));
      check($sformatf("v%0d_lat", v), 255'(lat), vecs[v].tout ? 255'd65 : 255'd21);
      if (vecs[v].chk_period)
        check($sformatf("v%0d_period_ge23", v), 255'(s - prev_s >= 23), 255'd1);
      prev_s = s;
    end
    req_valid = '0;
    stub_en = 1'b1;

    // Late done after a timeout must be ignored.
    late_done = 1'b1;
    step();
    late_done = 1'b0;
    check("late_done_busy", 255'(busy), 255'd0);
    step();
    check("late_done_valid", 255'(resp_valid), 255'd0);

    // Reset five cycles into BUSY.
    req_valid = 4'b0100;
    wait_grant(g);
    check("rst_job_id", 255'(g), 255'd2);
    step();
    req_valid = '0;
    repeat (5) step();
    check("rst_job_busy_before", 255'(busy), 255'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_valid", 255'(resp_valid), 255'd0);
    check("midrst_busy", 255'(busy), 255'd0);
    bad = 0;
    repeat (25) begin
      if (busy || resp_valid) bad++;
      step();
    end
    check("stale_done_ignored", 255'(bad), 255'd0);
    req_valid = 4'b1000;
    run_job(0, 1'b0, g, s, o, e, lat);
    req_valid = '0;
    check("post_rst_id", 255'(g), 255'd3);
    check("post_rst_out", o, dn(3) ^ dq(3));
    check("post_rst_err", 255'(e), 255'd0);

    // Request raised and dropped while the arbiter is in RESP creates no job.
    resp_ready = 1'b0;
    req_valid = 4'b0001;
    wait_grant(g);
    step();
    req_valid = '0;
    bad = 0;
    while (!resp_valid && bad < 100) begin
      step();
      bad++;
    end
    if (!resp_valid) timeout_fail("drop_resp");
    check("drop_job_id", 255'(resp_id), 255'd0);
    req_valid = 4'b0010;
    repeat (3) begin
      #1;
      check("drop_ready", 255'(req_ready), 255'd0);
      step();
    end
    req_valid = '0;
    resp_ready = 1'b1;
    step();
    bad = 0;
    repeat (10) begin
      if (busy || core_start) bad++;
      step();
    end
    check("drop_no_job", 255'(bad), 255'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
